// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state codes, default
// widths and the round-robin index wrap helper.
package fifo_arb_pkg;

  // FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // Default data width and statistics counter width
  localparam int DEF_DW = 8;
  localparam int STAT_W = 16;

  // Index k positions after ptr, wrapping modulo n (ptr < n, 1 <= k <= n)
  function automatic int idx_after(input int ptr, input int k, input int n);
    int s;
    s = ptr + k;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans requesters starting one
// position after ptr (wrapping) and returns the first one that is requesting
// and not masked by excl.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PW-1:0]    win_idx,
  output logic             win_any
);

  // First eligible requester after the pointer, in wrap order
  always_comb begin
    int          cand;
    logic [PW-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = idx_after(int'(ptr), k, N_REQ);
      cand_idx = PW'(cand);
      if (!win_any && req[cand_idx] && !excl[cand_idx]) begin
        win_any              = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ valid/ready producers, holding each grant for bursts of up to
// MAX_BURST beats so a producer's writes stay contiguous in the FIFO.
// Optional per-requester saturating transfer counters: define ARB_STATS_EN.
//
// Handshake: a beat moves from requester i to the FIFO in any cycle where
// req_valid[i] & req_ready[i]; req_ready[i] is grant[i] & ~fifo_full, so at
// most one beat moves per cycle and fifo_wr_en marks exactly that cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DW-1:0]         fifo_data_in,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy
`ifdef ARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [N_REQ*STAT_W-1:0] stat_xfer_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic             state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N_REQ-1:0] xfer_vec;
  logic             xfer;
  logic             gnt_valid;
  logic             release_burst;
  logic [PW-1:0]    pick_ptr;
  logic [N_REQ-1:0] pick_excl;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  assign req_ready  = grant_q & ~{N_REQ{fifo_full}};
  assign xfer_vec   = req_valid & req_ready;
  assign xfer       = |xfer_vec;
  assign fifo_wr_en = xfer;
  assign gnt_valid  = |(req_valid & grant_q);
  assign grant      = grant_q;
  assign busy       = (state_q == ST_BURST);

  // Grant ends when the grantee withdraws or its last allowed beat moves
  assign release_burst = (state_q == ST_BURST) &&
                         (!gnt_valid || (xfer && (cnt_q == LAST_BEAT)));

  // While bursting, search starts after (and excludes) the current grantee
  assign pick_ptr  = (state_q == ST_BURST) ? idx_q : ptr_q;
  assign pick_excl = (state_q == ST_BURST) ? grant_q : '0;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req        (req_valid),
    .ptr        (pick_ptr),
    .excl       (pick_excl),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_any    (pick_any)
  );

  // Data mux: grantee's slice, zero when nobody holds the grant
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) fifo_data_in = fifo_data_in | req_data[i*DW +: DW];
    end
  end

  // Next-state for FSM, grant, pointer and beat counter
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BURST;
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      default: begin
        if (release_burst) begin
          ptr_d = idx_q;
          cnt_d = '0;
          if (pick_any) begin
            grant_d = pick_onehot;
            idx_d   = pick_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Arbiter state registers; pointer resets so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [N_REQ*STAT_W-1:0] stat_q, stat_d;

  // Saturating per-requester beat counters; clear wins over a same-cycle beat
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (stat_clear) begin
        stat_d[i*STAT_W +: STAT_W] = '0;
      end else if (xfer_vec[i] && (stat_q[i*STAT_W +: STAT_W] != '1)) begin
        stat_d[i*STAT_W +: STAT_W] = stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_xfer_cnt = stat_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DW=8, MAX_BURST=4).
// Directed scenarios plus a randomized run against a behavioural model.
// Define ARB_STATS_EN to include the statistics scenario.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef ARB_STATS_EN
  logic            stat_clear;
  logic [N*16-1:0] stat_xfer_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant        (grant),
    .busy         (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_clear   (stat_clear),
    .stat_xfer_cnt(stat_xfer_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural reference model ----------------
  // m_g: current grantee index or -1 when idle; m_ptr: last grantee;
  // m_cnt: beats moved in the current grant.
  int m_g, m_ptr, m_cnt;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_g   = -1;
    m_ptr = N - 1;
    m_cnt = 0;
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_g >= 0) g[m_g] = 1'b1;
    return g;
  endfunction

  function automatic logic exp_wr();
    return (m_g >= 0) && req_valid[m_g] && !fifo_full;
  endfunction

  // Advance the model across one rising edge using the current inputs
  task automatic model_clock();
    logic x;
    int   nxt;
    if (m_g < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_g   = (m_ptr + k) % N;
          m_cnt = 0;
          break;
        end
      end
    end else begin
      x = req_valid[m_g] && !fifo_full;
      if (x) exp_q.push_back(req_data[m_g*DW +: DW]);
      if (!req_valid[m_g] || (x && m_cnt == MB - 1)) begin
        m_ptr = m_g;
        m_cnt = 0;
        nxt   = -1;
        for (int k = 1; k < N; k++) begin
          if (req_valid[(m_ptr + k) % N]) begin
            nxt = (m_ptr + k) % N;
            break;
          end
        end
        m_g = nxt;
      end else if (x) begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [N*DW-1:0] make_data(input int b[N]);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(16 * i + b[i]);
    return d;
  endfunction

  // Drive inputs just after the falling edge, then let them settle
  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic f);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    fifo_full = f;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
`ifdef ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = 32'hDEAD_BEEF;
    fifo_full = 1'b0;
`ifdef ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (grant !== '0)      begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== '0)  begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== '0) begin n_err++; $display("FAIL reset_data: got %h want 00", fifo_data_in); end
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
  endtask

  // Requester 0 alone sends 01..06: burst of 4, idle bubble, then 05,06
  task automatic test_single();
    logic [N-1:0] eg [10];
    int wr [10];
    int beats [N];
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
           4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    wr = '{-1, 0, 0, 0, 0, -1, 0, 0, -1, -1};
    apply_reset();
    beats = '{1, 0, 0, 0};
    for (int c = 0; c < 10; c++) begin
      drive((beats[0] <= 6) ? 4'b0001 : 4'b0000, make_data(beats), 1'b0);
      n_cmp++; if (grant !== eg[c]) begin n_err++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, eg[c]); end
      n_cmp++; if (busy !== (eg[c] != 0)) begin n_err++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, eg[c] != 0); end
      n_cmp++; if (fifo_wr_en !== (wr[c] >= 0)) begin n_err++; $display("FAIL single_wr_en c%0d: got %b want %b", c, fifo_wr_en, wr[c] >= 0); end
      if (wr[c] >= 0) begin
        n_cmp++;
        if (fifo_data_in !== DW'(beats[0])) begin n_err++; $display("FAIL single_data c%0d: got %h want %h", c, fifo_data_in, DW'(beats[0])); end
        beats[0]++;
      end
    end
  endtask

  // All four valid: 4 beats each in rotation 0,1,2,3,0 with no bubbles
  task automatic test_round_robin();
    int beats [N];
    int k;
    logic [N-1:0] eg;
    apply_reset();
    beats = '{0, 0, 0, 0};
    for (int c = 0; c < 21; c++) begin
      drive(4'b1111, make_data(beats), 1'b0);
      k  = (c - 1) / 4 % 4;
      eg = (c == 0) ? 4'b0000 : 4'(1 << k);
      n_cmp++; if (grant !== eg) begin n_err++; $display("FAIL rr_grant c%0d: got %b want %b", c, grant, eg); end
      n_cmp++; if (fifo_wr_en !== (c != 0)) begin n_err++; $display("FAIL rr_wr_en c%0d: got %b want %b", c, fifo_wr_en, c != 0); end
      if (c != 0) begin
        n_cmp++;
        if (fifo_data_in !== DW'(16 * k + beats[k])) begin n_err++; $display("FAIL rr_data c%0d: got %h want %h", c, fifo_data_in, DW'(16 * k + beats[k])); end
        beats[k]++;
      end
    end
  endtask

  // fifo_full held for 3 cycles after requester 2's second beat
  task automatic test_full_stall();
    logic [N-1:0] eg [10];
    logic ff [10];
    int wr [10];
    int beats [N];
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
           4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    ff = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    wr = '{-1, 2, 2, -1, -1, -1, 2, 2, 3, 3};
    apply_reset();
    beats = '{0, 0, 0, 0};
    for (int c = 0; c < 10; c++) begin
      drive(4'b1100, make_data(beats), ff[c]);
      n_cmp++; if (grant !== eg[c]) begin n_err++; $display("FAIL full_grant c%0d: got %b want %b", c, grant, eg[c]); end
      n_cmp++; if (req_ready !== (eg[c] & ~{N{ff[c]}})) begin n_err++; $display("FAIL full_ready c%0d: got %b want %b", c, req_ready, eg[c] & ~{N{ff[c]}}); end
      n_cmp++; if (fifo_wr_en !== (wr[c] >= 0)) begin n_err++; $display("FAIL full_wr_en c%0d: got %b want %b", c, fifo_wr_en, wr[c] >= 0); end
      if (wr[c] >= 0) begin
        n_cmp++;
        if (fifo_data_in !== DW'(16 * wr[c] + beats[wr[c]])) begin n_err++; $display("FAIL full_data c%0d: got %h want %h", c, fifo_data_in, DW'(16 * wr[c] + beats[wr[c]])); end
        beats[wr[c]]++;
      end
    end
  endtask

  // Requester 1 withdraws after 2 beats; grant moves to 3, then wraps to 0
  task automatic test_drop_valid();
    logic [N-1:0] vv [9];
    logic [N-1:0] eg [9];
    int wr [9];
    int beats [N];
    vv = '{4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1011,
           4'b1011, 4'b1011, 4'b1011, 4'b1011};
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000,
           4'b1000, 4'b1000, 4'b1000, 4'b0001};
    wr = '{-1, 1, 1, -1, 3, 3, 3, 3, 0};
    apply_reset();
    beats = '{0, 0, 0, 0};
    for (int c = 0; c < 9; c++) begin
      drive(vv[c], make_data(beats), 1'b0);
      n_cmp++; if (grant !== eg[c]) begin n_err++; $display("FAIL drop_grant c%0d: got %b want %b", c, grant, eg[c]); end
      n_cmp++; if (fifo_wr_en !== (wr[c] >= 0)) begin n_err++; $display("FAIL drop_wr_en c%0d: got %b want %b", c, fifo_wr_en, wr[c] >= 0); end
      if (wr[c] >= 0) begin
        n_cmp++;
        if (fifo_data_in !== DW'(16 * wr[c] + beats[wr[c]])) begin n_err++; $display("FAIL drop_data c%0d: got %h want %h", c, fifo_data_in, DW'(16 * wr[c] + beats[wr[c]])); end
        beats[wr[c]]++;
      end
    end
  endtask

  // Asynchronous reset in the middle of requester 0's burst
  task automatic test_reset_mid_burst();
    apply_reset();
    for (int c = 0; c < 3; c++) drive(4'b1001, {8'hB3, 16'h0000, 8'hA0}, 1'b0);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL mid_pre_grant: got %b want 0001", grant); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== '0)        begin n_err++; $display("FAIL mid_async_grant: got %b want 0000", grant); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_async_wr_en: got %b want 0", fifo_wr_en); end
    n_cmp++; if (req_ready !== '0)    begin n_err++; $display("FAIL mid_async_ready: got %b want 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL mid_post_idle: got %b want 0000", grant); end
    drive(4'b1001, {8'hB3, 16'h0000, 8'hA0}, 1'b0);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL mid_first_winner: got %b want 0001", grant); end
    n_cmp++; if (fifo_data_in !== 8'hA0) begin n_err++; $display("FAIL mid_first_data: got %h want a0", fifo_data_in); end
  endtask

  // Random valids, data and full flag checked against the model each cycle
  task automatic test_random();
    logic [DW-1:0]   prod_q [N][$];
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic            f;
    logic [DW-1:0]   e;
    int              written;
    apply_reset();
    exp_q.delete();
    written = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 12; j++) prod_q[i].push_back(DW'($urandom_range(0, 255)));
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = (prod_q[i].size() > 0) && ($urandom_range(0, 3) != 0);
        d[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : DW'($urandom_range(0, 255));
      end
      f = ($urandom_range(0, 4) == 0);
      drive(v, d, f);
      n_cmp++; if (grant !== exp_grant()) begin n_err++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant, exp_grant()); end
      n_cmp++; if (req_ready !== (exp_grant() & ~{N{f}})) begin n_err++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_grant() & ~{N{f}}); end
      n_cmp++; if (fifo_wr_en !== exp_wr()) begin n_err++; $display("FAIL rand_wr_en c%0d: got %b want %b", c, fifo_wr_en, exp_wr()); end
      n_cmp++; if (busy !== (m_g >= 0)) begin n_err++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_g >= 0); end
      model_clock();
      if (fifo_wr_en === 1'b1) begin
        written++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_sb c%0d: got write %h want no write", c, fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          if (fifo_data_in !== e) begin n_err++; $display("FAIL rand_sb c%0d: got %h want %h", c, fifo_data_in, e); end
        end
      end
      for (int i = 0; i < N; i++) if (v[i] && req_ready[i]) void'(prod_q[i].pop_front());
    end
    n_cmp++; if (written != N * 12) begin n_err++; $display("FAIL rand_total: got %0d want %0d", written, N * 12); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); end
  endtask

`ifdef ARB_STATS_EN
  // Transfer counters: 10 beats from 0, 3 from 2, clear, then saturation
  task automatic test_stats();
    int got;
    apply_reset();
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      drive(4'b0001, 32'h0000_0011, 1'b0);
      if (req_valid[0] && req_ready[0]) got++;
    end
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL stats_r0_timeout: got %0d want 10", got); end
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      drive(4'b0100, 32'h0022_0000, 1'b0);
      if (req_valid[2] && req_ready[2]) got++;
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL stats_r2_timeout: got %0d want 3", got); end
    drive(4'b0000, '0, 1'b0);
    drive(4'b0000, '0, 1'b0);
    n_cmp++; if (stat_xfer_cnt[15:0] !== 16'd10) begin n_err++; $display("FAIL stats_r0: got %0d want 10", stat_xfer_cnt[15:0]); end
    n_cmp++; if (stat_xfer_cnt[47:32] !== 16'd3) begin n_err++; $display("FAIL stats_r2: got %0d want 3", stat_xfer_cnt[47:32]); end
    n_cmp++; if (stat_xfer_cnt[31:16] !== 16'd0) begin n_err++; $display("FAIL stats_r1: got %0d want 0", stat_xfer_cnt[31:16]); end
    @(negedge clk); stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0; #1;
    n_cmp++; if (stat_xfer_cnt !== '0) begin n_err++; $display("FAIL stats_clear: got %h want 0", stat_xfer_cnt); end
    @(negedge clk); req_valid = 4'b0001;
    repeat (82000) @(negedge clk);
    #1;
    n_cmp++; if (stat_xfer_cnt[15:0] !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat: got %h want ffff", stat_xfer_cnt[15:0]); end
    stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0; req_valid = '0; #1;
    n_cmp++; if (stat_xfer_cnt[15:0] !== 16'h0000) begin n_err++; $display("FAIL stats_clear_xfer: got %h want 0000", stat_xfer_cnt[15:0]); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_valid();
    test_reset_mid_burst();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
